wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order pipeline writeback
//  (ALU / memory / PC+4 select) and a long-latency unit (mul/div, late load). One write per

---
 rtl/wb_port_arbiter_pkg.sv | 16 +
 rtl/wb_port_arbiter_if.sv | 59 +++++
 rtl/wb_port_arbiter_src_mux.sv | 35 +++
 rtl/wb_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
// Contents: writeback source select encodings and the arbiter FSM state type.
// Optional feature macro used by the arbiter: WB_FWD_EN (see wb_port_arbiter.sv).
package wb_pkg;

  localparam logic [1:0] WB_SRC_ALU    = 2'd0;
  localparam logic [1:0] WB_SRC_MEM    = 2'd1;
  localparam logic [1:0] WB_SRC_NEXTPC = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the arbiter's request / write-port signals.
//   master : request side (pipeline + long-latency unit) and write-port consumer
//   slave  : the arbiter itself
// Signals: p0_* pipeline writeback request, p1_* long-latency result request,
//          rf_* registered register-file write port.
// Macro WB_FWD_EN adds the forwarding lookup signals fwd_idx / fwd_hit / fwd_data.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 5
);
  logic              p0_valid;
  logic              p0_ready;
  logic [IDX_W-1:0]  p0_rd;
  logic [1:0]        p0_src;
  logic [DATA_W-1:0] p0_alu_result;
  logic [DATA_W-1:0] p0_mem_data;
  logic [ADDR_W-1:0] p0_pc;

  logic              p1_valid;
  logic              p1_ready;
  logic [IDX_W-1:0]  p1_rd;
  logic [DATA_W-1:0] p1_data;

  logic              rf_we;
  logic [IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

`ifdef WB_FWD_EN
  logic [IDX_W-1:0]  fwd_idx;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  modport master (
    output p0_valid, p0_rd, p0_src, p0_alu_result, p0_mem_data, p0_pc,
    output p1_valid, p1_rd, p1_data, fwd_idx,
    input  p0_ready, p1_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data
  );

  modport slave (
    input  p0_valid, p0_rd, p0_src, p0_alu_result, p0_mem_data, p0_pc,
    input  p1_valid, p1_rd, p1_data, fwd_idx,
    output p0_ready, p1_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data
  );
`else
  modport master (
    output p0_valid, p0_rd, p0_src, p0_alu_result, p0_mem_data, p0_pc,
    output p1_valid, p1_rd, p1_data,
    input  p0_ready, p1_ready, rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  p0_valid, p0_rd, p0_src, p0_alu_result, p0_mem_data, p0_pc,
    input  p1_valid, p1_rd, p1_data,
    output p0_ready, p1_ready, rf_we, rf_waddr, rf_wdata
  );
`endif

endinterface

// File: rtl/wb_port_arbiter_src_mux.sv
// Pipeline writeback data select.
// Ports:
//   src        in  2       source select (ALU / memory / next instruction address)
//   alu_result in  DATA_W
//   mem_data   in  DATA_W
//   pc         in  ADDR_W  instruction address; next-PC source returns pc+4
//   data       out DATA_W  selected writeback value
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic [1:0]        src,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] data
);

  logic [ADDR_W-1:0] pc_plus4;

  assign pc_plus4 = pc + ADDR_W'(4);

  // Reserved encoding 2 falls through to the ALU result.
  always_comb begin
    data = alu_result;
    case (src)
      WB_SRC_MEM:    data = mem_data;
      WB_SRC_NEXTPC: data = DATA_W'(pc_plus4);
      default:       data = alu_result;
    endcase
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares one registered write port between the
// in-order pipeline writeback (p0) and a long-latency unit (p1). p0 normally wins;
// a losing p1 result waits in a 1-entry skid register, and after STARVE_LIMIT
// consecutive losses p0 is stalled for one cycle so the skid entry drains.
//
// state | meaning
// IDLE  | skid empty; p1 may write straight through when p0 is idle
// PEND  | skid holds a p1 result that has lost to p0
// FORCE | p1 starved STARVE_LIMIT times; p0 stalled, skid drains this cycle
//
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_port_arbiter_if.slave (p0_*, p1_* requests; rf_* write port)
// Macro WB_FWD_EN: adds a combinational forwarding lookup (fwd_idx -> fwd_hit/fwd_data)
// against the pending rf_* write (priority) and the skid entry.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int IDX_W        = 5,
  parameter int STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  wb_state_e         state;
  logic [CNT_W-1:0]  starve_cnt;
  logic [CNT_W-1:0]  starve_cnt_inc;

  logic              skid_valid;
  logic [IDX_W-1:0]  skid_rd;
  logic [DATA_W-1:0] skid_data;

  logic              rf_we_q;
  logic [IDX_W-1:0]  rf_waddr_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic [DATA_W-1:0] p0_data;
  logic              p0_fire;
  logic              p1_fire;

  wb_src_mux #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_src_mux (
    .src       (bus.p0_src),
    .alu_result(bus.p0_alu_result),
    .mem_data  (bus.p0_mem_data),
    .pc        (bus.p0_pc),
    .data      (p0_data)
  );

  assign bus.p0_ready = (state != FORCE);
  assign bus.p1_ready = !skid_valid;
  assign p0_fire      = bus.p0_valid && bus.p0_ready;
  assign p1_fire      = bus.p1_valid && bus.p1_ready;
  assign starve_cnt_inc = starve_cnt + CNT_ONE;

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  // Writes to x0 still complete the handshake; they just never raise rf_we.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      skid_valid <= 1'b0;
      skid_rd    <= '0;
      skid_data  <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (p0_fire) begin
            rf_we_q    <= (bus.p0_rd != '0);
            rf_waddr_q <= bus.p0_rd;
            rf_wdata_q <= p0_data;
            if (p1_fire) begin
              // The capture cycle already counts as the first loss for p1.
              skid_valid <= 1'b1;
              skid_rd    <= bus.p1_rd;
              skid_data  <= bus.p1_data;
              starve_cnt <= CNT_ONE;
              state      <= (CNT_ONE == CNT_MAX) ? FORCE : PEND;
            end
          end else if (p1_fire) begin
            rf_we_q    <= (bus.p1_rd != '0);
            rf_waddr_q <= bus.p1_rd;
            rf_wdata_q <= bus.p1_data;
          end
        end
        PEND: begin
          if (p0_fire) begin
            rf_we_q    <= (bus.p0_rd != '0);
            rf_waddr_q <= bus.p0_rd;
            rf_wdata_q <= p0_data;
            starve_cnt <= starve_cnt_inc;
            if (starve_cnt_inc == CNT_MAX) state <= FORCE;
          end else begin
            rf_we_q    <= (skid_rd != '0);
            rf_waddr_q <= skid_rd;
            rf_wdata_q <= skid_data;
            skid_valid <= 1'b0;
            starve_cnt <= '0;
            state      <= IDLE;
          end
        end
        FORCE: begin
          rf_we_q    <= (skid_rd != '0);
          rf_waddr_q <= skid_rd;
          rf_wdata_q <= skid_data;
          skid_valid <= 1'b0;
          starve_cnt <= '0;
          state      <= IDLE;
        end
        default: begin
          skid_valid <= 1'b0;
          starve_cnt <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

`ifdef WB_FWD_EN
  logic fwd_rf_hit;
  logic fwd_skid_hit;

  // The rf_* write is younger than the skid entry only in the sense that it lands
  // first; it is the value the register file will hold next cycle, so it wins.
  assign fwd_rf_hit   = rf_we_q && (rf_waddr_q == bus.fwd_idx);
  assign fwd_skid_hit = skid_valid && (skid_rd == bus.fwd_idx);
  assign bus.fwd_hit  = (bus.fwd_idx != '0) && (fwd_rf_hit || fwd_skid_hit);
  assign bus.fwd_data = fwd_rf_hit ? rf_wdata_q : skid_data;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  wb_port_arbiter_if #(.DATA_W(32), .ADDR_W(32), .IDX_W(5)) bus ();

  wb_port_arbiter #(
    .DATA_W(32),
    .ADDR_W(32),
    .IDX_W(5),
    .STARVE_LIMIT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.p0_valid      = 1'b0;
    bus.p0_rd         = '0;
    bus.p0_src        = 2'd0;
    bus.p0_alu_result = '0;
    bus.p0_mem_data   = '0;
    bus.p0_pc         = '0;
    bus.p1_valid      = 1'b0;
    bus.p1_rd         = '0;
    bus.p1_data       = '0;
`ifdef WB_FWD_EN
    bus.fwd_idx       = '0;
`endif
  endtask

  task automatic expect_write(input string name, input logic we,
                              input logic [4:0] waddr, input logic [31:0] wdata);
    checks++;
    if (bus.rf_we !== we) begin
      errors++;
      $display("FAIL %s rf_we actual %0b required %0b", name, bus.rf_we, we);
    end
    if (we) begin
      checks++;
      if (bus.rf_waddr !== waddr || bus.rf_wdata !== wdata) begin
        errors++;
        $display("FAIL %s rf_waddr/rf_wdata actual %0d/%h required %0d/%h",
                 name, bus.rf_waddr, bus.rf_wdata, waddr, wdata);
      end
    end
  endtask

  task automatic expect_ready(input string name, input logic r0, input logic r1);
    checks++;
    if (bus.p0_ready !== r0 || bus.p1_ready !== r1) begin
      errors++;
      $display("FAIL %s p0_ready/p1_ready actual %0b/%0b required %0b/%0b",
               name, bus.p0_ready, bus.p1_ready, r0, r1);
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs actual we=%0b addr=%0d data=%h required 0/0/0",
               bus.rf_we, bus.rf_waddr, bus.rf_wdata);
    end
    expect_ready("reset_ready", 1'b1, 1'b1);
  endtask

  task automatic test_src_select();
    logic [1:0]  v_src  [5];
    logic [31:0] v_alu  [5];
    logic [31:0] v_mem  [5];
    logic [31:0] v_pc   [5];
    logic [4:0]  v_rd   [5];
    logic [31:0] v_exp  [5];
    v_src[0] = 2'd0; v_alu[0] = 32'h11;   v_mem[0] = 32'h99;   v_pc[0] = 32'h40;       v_rd[0] = 5'd5; v_exp[0] = 32'h11;
    v_src[1] = 2'd3; v_alu[1] = 32'hDEAD; v_mem[1] = 32'hBEEF; v_pc[1] = 32'h100;      v_rd[1] = 5'd1; v_exp[1] = 32'h104;
    v_src[2] = 2'd1; v_alu[2] = 32'h5;    v_mem[2] = 32'hAB;   v_pc[2] = 32'h200;      v_rd[2] = 5'd2; v_exp[2] = 32'hAB;
    v_src[3] = 2'd2; v_alu[3] = 32'h77;   v_mem[3] = 32'hAB;   v_pc[3] = 32'h300;      v_rd[3] = 5'd6; v_exp[3] = 32'h77;
    v_src[4] = 2'd3; v_alu[4] = 32'h1;    v_mem[4] = 32'h2;    v_pc[4] = 32'hFFFFFFFC; v_rd[4] = 5'd31; v_exp[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      bus.p0_valid      = 1'b1;
      bus.p0_src        = v_src[i];
      bus.p0_alu_result = v_alu[i];
      bus.p0_mem_data   = v_mem[i];
      bus.p0_pc         = v_pc[i];
      bus.p0_rd         = v_rd[i];
      expect_ready($sformatf("src%0d_ready", i), 1'b1, 1'b1);
      tick();
      clear_inputs();
      expect_write($sformatf("src%0d_write", i), 1'b1, v_rd[i], v_exp[i]);
      tick();
      expect_write($sformatf("src%0d_pulse", i), 1'b0, 5'd0, 32'd0);
    end
  endtask

  task automatic test_p1_direct();
    bus.p1_valid = 1'b1;
    bus.p1_rd    = 5'd7;
    bus.p1_data  = 32'h77;
    tick();
    clear_inputs();
    expect_write("p1_direct_write", 1'b1, 5'd7, 32'h77);
    expect_ready("p1_direct_ready", 1'b1, 1'b1);
    tick();
    expect_write("p1_direct_pulse", 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_collision();
    bus.p0_valid      = 1'b1;
    bus.p0_rd         = 5'd3;
    bus.p0_src        = 2'd0;
    bus.p0_alu_result = 32'h33;
    bus.p1_valid      = 1'b1;
    bus.p1_rd         = 5'd4;
    bus.p1_data       = 32'h44;
    tick();
    clear_inputs();
    expect_write("collide_p0_first", 1'b1, 5'd3, 32'h33);
    expect_ready("collide_skid_full", 1'b1, 1'b0);
    tick();
    expect_write("collide_p1_second", 1'b1, 5'd4, 32'h44);
    expect_ready("collide_skid_empty", 1'b1, 1'b1);
    tick();
    expect_write("collide_quiet", 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_starve();
    for (int i = 0; i < 4; i++) begin
      bus.p0_valid      = 1'b1;
      bus.p0_src        = 2'd0;
      bus.p0_rd         = 5'(10 + i);
      bus.p0_alu_result = 32'h100 + 32'(i);
      if (i == 0) begin
        bus.p1_valid = 1'b1;
        bus.p1_rd    = 5'd20;
        bus.p1_data  = 32'h2020;
      end
      tick();
      bus.p1_valid = 1'b0;
      expect_write($sformatf("starve_p0_win%0d", i), 1'b1, 5'(10 + i), 32'h100 + 32'(i));
      expect_ready($sformatf("starve_ready%0d", i), (i < 3) ? 1'b1 : 1'b0, 1'b0);
    end
    bus.p0_rd         = 5'd14;
    bus.p0_alu_result = 32'h114;
    tick();
    expect_write("starve_p1_forced", 1'b1, 5'd20, 32'h2020);
    expect_ready("starve_after_force", 1'b1, 1'b1);
    tick();
    clear_inputs();
    expect_write("starve_p0_resume", 1'b1, 5'd14, 32'h114);
    tick();
  endtask

  task automatic test_rd_zero();
    bus.p0_valid      = 1'b1;
    bus.p0_rd         = 5'd0;
    bus.p0_alu_result = 32'h55;
    expect_ready("rd0_p0_ready", 1'b1, 1'b1);
    tick();
    clear_inputs();
    expect_write("rd0_p0_dropped", 1'b0, 5'd0, 32'd0);
    bus.p1_valid = 1'b1;
    bus.p1_rd    = 5'd0;
    bus.p1_data  = 32'h66;
    expect_ready("rd0_p1_ready", 1'b1, 1'b1);
    tick();
    clear_inputs();
    expect_write("rd0_p1_dropped", 1'b0, 5'd0, 32'd0);
    expect_ready("rd0_p1_no_skid", 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_pend();
    bus.p0_valid      = 1'b1;
    bus.p0_rd         = 5'd3;
    bus.p0_alu_result = 32'h33;
    bus.p1_valid      = 1'b1;
    bus.p1_rd         = 5'd4;
    bus.p1_data       = 32'h44;
    tick();
    clear_inputs();
    expect_ready("rstpend_pending", 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_write("rstpend_no_write", 1'b0, 5'd0, 32'd0);
    expect_ready("rstpend_ready", 1'b1, 1'b1);
    tick();
    expect_write("rstpend_skid_gone", 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_src_select();
    test_p1_direct();
    test_collision();
    test_starve();
    test_rd_zero();
    test_reset_mid_pend();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
